// File: rtl/tx_arbiter.sv
// Round-robin arbiter that hands frames from two requesters to a serial transmitter.
// It enforces a start timeout and an idle gap between consecutive frames.
module tx_arbiter #(
    parameter int DATA_W        = 8,
    parameter int GAP_CYCLES    = 5200,
    parameter int START_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                err_q, err_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                win;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        to_cnt_d   = to_cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        err_d      = 1'b0;
        tx_start_d = 1'b0;
        // On a tie the requester that was not granted last wins; a lone request always wins.
        win        = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d    = win;
                    last_d     = win;
                    tx_data_d  = win ? data1 : data0;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    tx_start_d = 1'b1;
                    to_cnt_d   = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (tx_busy) begin
                    to_cnt_d = '0;
                    state_d  = BUSY;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (!tx_busy) begin
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign err      = err_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the frame payload width.
REQ-002 Parameter GAP_CYCLES, default 5200, SHALL set the idle clocks enforced between frames (one bit time).
REQ-003 Parameter START_TIMEOUT, default 16, SHALL set the clocks allowed for tx_busy to rise after tx_start.
REQ-004 Port list:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0  input  1  requester 0 frame request.
- data0  input  DATA_W  requester 0 payload.
- req1  input  1  requester 1 frame request.
- data1  input  DATA_W  requester 1 payload.
- gnt0  output  1  one-cycle pulse: data0 captured.
- gnt1  output  1  one-cycle pulse: data1 captured.
- done0  output  1  one-cycle pulse: requester 0 frame finished.
- done1  output  1  one-cycle pulse: requester 1 frame finished.
- err  output  1  one-cycle pulse: start timeout.
- tx_start  output  1  one-cycle start pulse to serial transmitter.
- tx_data  output  DATA_W  payload to transmitter; held stable from start to frame end.
- tx_busy  input  1  transmitter frame in progress.

Function
REQ-005 All outputs SHALL be registered.
REQ-006 FSM states SHALL be IDLE, START, BUSY, GAP.
REQ-007 IDLE: if req0 or req1 is sampled high, the arbiter SHALL select a winner, load tx_data with its payload, and go to START at the next edge.
REQ-008 Arbitration SHALL be round-robin: with both requests high, the requester not granted last SHALL win; a lone request SHALL win regardless of history.
REQ-009 On entry to START, gntN for the winner and tx_start SHALL each be high for exactly one cycle.
REQ-010 START: when tx_busy is sampled high, the FSM SHALL go to BUSY.
- Timeout: if tx_busy stays low for START_TIMEOUT cycles after tx_start, err SHALL pulse once.
- Timeout: the FSM SHALL return to IDLE with no doneN pulse.
- Timeout: the last-grant pointer SHALL still advance.
REQ-011 BUSY: on the first cycle tx_busy is sampled low, doneN SHALL pulse once for the owner, and the FSM SHALL enter GAP.
REQ-012 GAP: a counter SHALL run from 0 to GAP_CYCLES-1, then return to IDLE. Requests seen during GAP SHALL NOT be granted until IDLE.
REQ-013 The gap counter SHALL be ceil(log2(GAP_CYCLES+1)) bits wide, and the timeout counter ceil(log2(START_TIMEOUT+1)) bits wide. Neither SHALL wrap; each SHALL clear on leaving its state.
REQ-014 tx_data SHALL change only in the IDLE->START transition.
REQ-015 A requester SHALL hold reqN and dataN until gntN. The arbiter SHALL ignore reqN deasserted before grant, and SHALL NOT queue requests.
REQ-016 Request-to-tx_start latency SHALL be exactly 1 clock from the IDLE sampling edge.
REQ-017 A request still high after its doneN SHALL be treated as a new frame request.

Reset
REQ-018 While rst is high at an edge, the following SHALL be forced:
- state IDLE; counters 0.
- gnt0, gnt1, done0, done1, err, tx_start = 0; tx_data = 0.
- last-grant = requester 1, so requester 0 wins the first tie.
REQ-019 rst SHALL take priority over every transition. An in-flight frame SHALL be abandoned with no doneN or err pulse.

Verification (GAP_CYCLES=4, START_TIMEOUT=8)
REQ-020 Single request: req0=1, data0=8'hA5; tx_busy rises 2 cycles after tx_start and stays high 10 cycles.
- Expect gnt0 and tx_start pulses 1 clock after req0 is sampled.
- Expect tx_data=8'hA5; done0 pulse after tx_busy falls.
- Expect the next grant no earlier than 4 cycles later.
REQ-021 Tie, twice: req0=req1=1 held after reset.
- Expect gnt0 first, then gnt1, then gnt0: alternation.
REQ-022 Timeout: req1=1, tx_busy tied 0.
- Expect err pulse 8 cycles after tx_start, no done1, return to IDLE.
- Next tie expect gnt0.
REQ-023 Reset mid-frame: assert rst during BUSY.
- Expect next-cycle outputs all 0, state IDLE, no done pulse.
- First tie after reset expect gnt0.
REQ-024 Gap blocking: req1 rises during GAP.
- Expect gnt1 exactly 1 clock after the GAP->IDLE edge, never during GAP.
